serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, operand and result width in bits (>= 2).
REQ-002 The module SHALL have parameter DIGIT, default 1, bits added per clock; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 The module SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port start  input  1  request to begin an addition; sampled only when not busy.
REQ-006 The module SHALL have port a  input  WIDTH  first operand, captured on an accepted start.
REQ-007 The module SHALL have port b  input  WIDTH  second operand, captured on an accepted start.
REQ-008 The module SHALL have port cin  input  1  carry-in, captured on an accepted start.
REQ-009 The module SHALL have port sub  input  1  subtract request, captured on an accepted start (see Configuration).
REQ-010 The module SHALL have port busy  output  1  high while the operation is in progress.
REQ-011 The module SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-012 The module SHALL have port sum  output  WIDTH  result register.
REQ-013 The module SHALL have port cout  output  1  carry out of the MSB.
REQ-014 The module SHALL have port overflow  output  1  two's-complement signed overflow.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; busy=1 only in RUN, and done=1 only in DONE.
REQ-016 In IDLE or DONE, start=1 at an edge SHALL capture a, b, cin and sub, clear the digit counter, and enter RUN.
REQ-017 In DONE with start=0, the FSM SHALL return to IDLE at the next edge, so done is exactly one cycle wide.
REQ-018 Each RUN edge SHALL add one DIGIT-bit slice, LSB slice first, using the registered carry, store the slice into sum, update the carry, and increment the counter.
REQ-019 At the N-th RUN edge, with N = WIDTH/DIGIT, the FSM SHALL enter DONE; done SHALL rise exactly N edges after the start-sampling edge.
REQ-020 sum, cout and overflow SHALL be valid while done=1 and SHALL hold until the next accepted start.
REQ-021 Intermediate sum bits MAY be visible during RUN, and cout and overflow SHALL NOT change during RUN.
REQ-022 The result SHALL be {cout, sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-023 overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-024 start while busy SHALL be ignored, with no effect on operands, counter or result.
REQ-025 Input changes during RUN SHALL NOT affect the result, because operands are captured.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE and clear busy, done, sum, cout, overflow, the carry register and the counter to 0.
REQ-027 reset SHALL take priority over start.
REQ-028 reset during RUN SHALL abandon the operation with no done pulse.
REQ-029 The first start after reset is released SHALL behave as from a fresh IDLE.

Configuration
REQ-030 Macro SERIAL_ADDER_SUB_EN defined: when sub is captured high, the operation SHALL be a - b, computed as a + ~b + 1; cin SHALL be ignored; cout SHALL be 1 when no borrow occurs; overflow SHALL be the signed subtraction overflow.
REQ-031 SERIAL_ADDER_SUB_EN undefined: the sub port SHALL remain present but be ignored, and every operation SHALL be an addition.

Verification
REQ-032 WIDTH=8, DIGIT=1: a=FF, b=01, cin=0, start pulse -> done 8 edges later; sum=00, cout=1, overflow=0; busy high for exactly 8 cycles.
REQ-033 WIDTH=8, DIGIT=1: a=7F, b=00, cin=1 -> sum=80, cout=0, overflow=1.
REQ-034 WIDTH=8, DIGIT=4, SERIAL_ADDER_SUB_EN defined: a=05, b=07, sub=1 -> done 2 edges after start; sum=FE, cout=0, overflow=0. With the macro undefined, the same stimulus -> sum=0C.
REQ-035 start re-asserted with new operands during RUN -> ignored; the original result is delivered. start held high during the DONE cycle -> a new operation begins with no IDLE gap.
REQ-036 reset pulsed at the 3rd RUN edge of an 8-cycle operation -> no done pulse; all outputs 0. A following start of 12+34 -> sum=46 after 8 edges.

Source files
------------

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Digit-serial adder/subtractor. An accepted start captures both operands and
// the carry-in. The adder then processes DIGIT bits per clock, least
// significant slice first, and holds the result until the next accepted start.
//
// Parameters
//   WIDTH  operand and result width in bits (>= 2)
//   DIGIT  bits added per clock; WIDTH must be an integer multiple of DIGIT
//
// Ports
//   clk       in   single clock; all state changes on its rising edge
//   reset     in   synchronous, active-high reset
//   start     in   begin an addition; sampled only when not busy
//   a, b      in   WIDTH-bit operands, captured on an accepted start
//   cin       in   carry-in, captured on an accepted start
//   sub       in   subtract request, captured on an accepted start
//   busy      out  high while the operation is in progress (RUN)
//   done      out  one-cycle pulse marking a valid result (DONE)
//   sum       out  WIDTH-bit result register
//   cout      out  carry out of the MSB
//   overflow  out  two's-complement signed overflow
//
// Configuration
//   SERIAL_ADDER_SUB_EN  when defined, sub=1 computes a - b as a + ~b + 1 and
//                        ignores cin. cout=1 then means "no borrow". When the
//                        macro is undefined, sub is ignored and every operation
//                        is an addition.
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cout_q, cout_d;
    logic               overflow_q, overflow_d;

    logic [DIGIT:0]       slice_total;
    logic [DIGIT-1:0]     slice_sum;
    logic                 slice_carry;
    logic                 msb_carry_in;
    logic [WIDTH+DIGIT-1:0] sum_shifted;
    logic                 last_slice;

    // The operand registers shift right by DIGIT on every RUN edge, so the
    // slice being added is always the bottom DIGIT bits of each register.
    // The carry into the MSB is recovered from the MSB sum bit, because
    // s = a ^ b ^ cin for every bit position. This avoids a second adder
    // that would only exist to compute the overflow flag.
    assign slice_total  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                        + {{DIGIT{1'b0}}, carry_q};
    assign slice_sum    = slice_total[DIGIT-1:0];
    assign slice_carry  = slice_total[DIGIT];
    assign msb_carry_in = slice_sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

    // Each new slice enters the result at the top and moves down. After N
    // slices, the first slice has reached bit 0.
    assign sum_shifted  = {slice_sum, sum_q};
    assign last_slice   = (cnt_q == CNT_W'(N - 1));

`ifndef SERIAL_ADDER_SUB_EN
    logic unused_sub;
    assign unused_sub = sub;
`endif

    // Next-state and datapath logic. Subtraction is folded into the
    // operand capture: b is inverted and the carry register is preloaded
    // with 1. The serial loop therefore only ever performs an addition.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_ADDER_SUB_EN
                    if (sub) begin
                        b_d     = ~b;
                        carry_d = 1'b1;
                    end else begin
                        b_d     = b;
                        carry_d = cin;
                    end
`else
                    b_d     = b;
                    carry_d = cin;
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                sum_d   = sum_shifted[WIDTH+DIGIT-1:DIGIT];
                carry_d = slice_carry;
                cnt_d   = cnt_q + 1'b1;
                if (last_slice) begin
                    cout_d     = slice_carry;
                    overflow_d = msb_carry_in ^ slice_carry;
                    state_d    = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset abandons any operation in progress and clears
    // the visible result along with the internal carry and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder. The main instance uses WIDTH=8 and
// DIGIT=1. A second instance uses WIDTH=8 and DIGIT=4 and exercises the
// multi-bit digit path. Expected results come from a fixed vector table, a
// plain-arithmetic reference model and hand-written corner sequences.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       overflow;

    logic       start4;
    logic [7:0] a4;
    logic [7:0] b4;
    logic       cin4;
    logic       sub4;
    logic       busy4;
    logic       done4;
    logic [7:0] sum4;
    logic       cout4;
    logic       overflow4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[6];

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk      (clk),
        .reset    (reset),
        .start    (start4),
        .a        (a4),
        .b        (b4),
        .cin      (cin4),
        .sub      (sub4),
        .busy     (busy4),
        .done     (done4),
        .sum      (sum4),
        .cout     (cout4),
        .overflow (overflow4)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Reference model written in ordinary integer arithmetic. It returns
    // {overflow, cout, sum}.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic c, input logic s);
        int full;
        int sres;
        logic [7:0] r;
        logic co;
        logic ov;
`ifdef SERIAL_ADDER_SUB_EN
        if (s) begin
            full = int'(x) - int'(y);
            r    = full[7:0];
            co   = (x >= y);
            sres = int'($signed(x)) - int'($signed(y));
            ov   = (sres > 127) || (sres < -128);
            return {ov, co, r};
        end
`else
        if (s) begin
            full = 0;
        end
`endif
        full = int'(x) + int'(y) + int'(c);
        r    = full[7:0];
        co   = full[8];
        sres = int'($signed(x)) + int'($signed(y)) + int'(c);
        ov   = (sres > 127) || (sres < -128);
        return {ov, co, r};
    endfunction

    // Compare one value and record the outcome.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Pulse start for one edge on the DIGIT=1 instance, then wait for done
    // within a bounded number of edges. The task also reports the latency
    // in edges and the number of busy cycles.
    task automatic applyStimulus(input logic [7:0] a_i, input logic [7:0] b_i,
                                 input logic cin_i, input logic sub_i,
                                 output int lat, output int busy_cycles);
        @(negedge clk);
        a     = a_i;
        b     = b_i;
        cin   = cin_i;
        sub   = sub_i;
        start = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        lat         = 0;
        busy_cycles = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cycles++;
        end
    endtask

    // Stop the run if something hangs well beyond the expected run time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        int lat;
        int bc;
        int n;
        int seen;
        logic [9:0] exp;
        logic [7:0] ra;
        logic [7:0] rb;
        logic rc;
        logic rs;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[3] = '{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
`ifdef SERIAL_ADDER_SUB_EN
        vecs[4] = '{8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
`else
        vecs[4] = '{8'h01, 8'h02, 1'b1, 1'b1, 8'h04, 1'b0, 1'b0};
`endif
        vecs[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

        reset  = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        sub    = 1'b0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        cin4   = 1'b0;
        sub4   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_sum", sum, 0);
        checkOutput("reset_cout", cout, 0);
        checkOutput("reset_ovf", overflow, 0);
        checkOutput("reset_busy4", busy4, 0);
        @(negedge clk);
        reset = 1'b0;

        // Fixed vector table. Vector 5 leaves cout and overflow set, which
        // the reset sequence below then needs to clear.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat, bc);
            checkOutput($sformatf("vec%0d_latency", i), lat, 8);
            checkOutput($sformatf("vec%0d_busy_cycles", i), bc, 8);
            checkOutput($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
            checkOutput($sformatf("vec%0d_cout", i), cout, vecs[i].cout);
            checkOutput($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_done_one_cycle", i), done, 0);
            checkOutput($sformatf("vec%0d_sum_held", i), sum, vecs[i].sum);
        end

        // Reset asserted at the 3rd RUN edge: the operation is abandoned
        // with no done pulse, and all outputs return to zero.
        @(negedge clk);
        a     = 8'h33;
        b     = 8'h44;
        cin   = 1'b0;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("midrun_reset_busy", busy, 0);
        checkOutput("midrun_reset_done", done, 0);
        checkOutput("midrun_reset_sum", sum, 0);
        checkOutput("midrun_reset_cout", cout, 0);
        checkOutput("midrun_reset_ovf", overflow, 0);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        checkOutput("midrun_reset_no_done", seen, 0);
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, lat, bc);
        checkOutput("after_reset_latency", lat, 8);
        checkOutput("after_reset_sum", sum, 8'h46);

        // Reset takes priority over a simultaneous start.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h01;
        @(posedge clk);
        #1;
        checkOutput("reset_priority_busy", busy, 0);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_priority_idle", busy, 0);

        // A start pulsed during RUN, and input changes during RUN, are both
        // ignored. The original result arrives on the original schedule.
        @(negedge clk);
        a     = 8'h10;
        b     = 8'h20;
        cin   = 1'b0;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'hA5;
        b     = 8'h5A;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("ignored_start_latency", n, 5);
        checkOutput("ignored_start_sum", sum, 8'h30);
        checkOutput("ignored_start_cout", cout, 0);

        // Start held through the DONE cycle begins the next operation with
        // no IDLE gap. applyStimulus returns in the DONE cycle, so calling
        // it again right away samples start while the DUT is still in DONE.
        applyStimulus(8'hC8, 8'h64, 1'b0, 1'b0, lat, bc);
        checkOutput("b2b_first_sum", sum, 8'h2C);
        checkOutput("b2b_first_cout", cout, 1);
        applyStimulus(8'h0F, 8'h01, 1'b1, 1'b0, lat, bc);
        checkOutput("b2b_second_latency", lat, 8);
        checkOutput("b2b_second_busy_cycles", bc, 8);
        checkOutput("b2b_second_sum", sum, 8'h11);

        // DIGIT=4 instance: two edges per operation.
        @(negedge clk);
        a4     = 8'h05;
        b4     = 8'h07;
        cin4   = 1'b0;
        sub4   = 1'b1;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("digit4_latency", n, 2);
`ifdef SERIAL_ADDER_SUB_EN
        checkOutput("digit4_sum", sum4, 8'hFE);
`else
        checkOutput("digit4_sum", sum4, 8'h0C);
`endif
        checkOutput("digit4_cout", cout4, 0);
        checkOutput("digit4_ovf", overflow4, 0);

        // Randomised operations checked against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rc  = 1'($urandom_range(0, 1));
            rs  = 1'($urandom_range(0, 1));
            exp = model(ra, rb, rc, rs);
            applyStimulus(ra, rb, rc, rs, lat, bc);
            checkOutput($sformatf("rand%0d_latency", i), lat, 8);
            checkOutput($sformatf("rand%0d_sum(a=%0h b=%0h c=%0b s=%0b)", i, ra, rb, rc, rs),
                        sum, exp[7:0]);
            checkOutput($sformatf("rand%0d_cout", i), cout, exp[8]);
            checkOutput($sformatf("rand%0d_ovf", i), overflow, exp[9]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
